// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader, the IM and the CPU top.
//   ImAddrW            default IM word-address width
//   ImDepth            IM depth in words
//   ByteOrderBigEndian first byte of a word lands in bits [31:24] when set
//   state_e            loader FSM state encoding
//   pack_byte          shifts one stream byte into a partially assembled word
package im_loader_pkg;

  localparam int unsigned ImAddrW = 10;
  localparam int unsigned ImDepth = 1 << ImAddrW;
  localparam bit ByteOrderBigEndian = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StCheck,
    StDone
  } state_e;

  function automatic logic [31:0] pack_byte(input logic [31:0] word, input logic [7:0] b);
    if (ByteOrderBigEndian) begin
      return {word[23:0], b};
    end else begin
      return {b, word[31:8]};
    end
  endfunction

endpackage

// File: rtl/im_loader_if.sv
// Host/IM-side bundle of the instruction-memory loader.
//   master : host front-end (drives start, word_count, byte_valid, byte_data)
//   slave  : loader (drives byte_ready, im_we, im_waddr, im_wdata, cpu_hold, done, err)
interface im_loader_if
  import im_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ImAddrW
) ();

  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, im_we, im_waddr, im_wdata, cpu_hold, done, err
  );

  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, im_we, im_waddr, im_wdata, cpu_hold, done, err
  );

endinterface

// File: rtl/im_loader_byte_packer.sv
// Assembles four stream bytes into one 32-bit word.
//   clk, reset   clock and synchronous active-low reset
//   clear_i      drop any partial word and restart at byte 0
//   push_i       one byte accepted this cycle
//   byte_i       the accepted byte
//   word_o       word including the byte currently pushed (valid with word_full_o)
//   word_full_o  high in the cycle the fourth byte of a word is pushed
module im_loader_byte_packer
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [31:0] sr_q;
  logic [1:0]  idx_q;

  // The word is presented combinationally with its last byte so the loader can
  // register it on the same edge and write it in the very next cycle.
  assign word_o      = pack_byte(sr_q, byte_i);
  assign word_full_o = push_i && (idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (clear_i) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (push_i) begin
      sr_q  <= word_o;
      idx_q <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: packs a byte stream into words, writes them to IM from
// address 0 upward and holds the CPU until the image is complete.
//   clk, reset  clock and synchronous active-low reset
//   bus         im_loader_if.slave: start/word_count, byte stream, IM write port,
//               cpu_hold, done, err
// Optional feature: define IM_LOADER_CSUM_EN to require one trailing checksum byte
// (XOR of all program bytes) after the last word; a mismatch ends with err=1.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ImAddrW
) (
  input logic        clk,
  input logic        reset,
  im_loader_if.slave bus
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] MaxWords = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic              byte_ready_q, byte_ready_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   written_q, written_d;

  logic        accept;
  logic        pk_clear;
  logic        pk_push;
  logic        pk_full;
  logic [31:0] pk_word;

`ifdef IM_LOADER_CSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  assign accept  = bus.byte_valid && byte_ready_q;
  assign pk_push = accept && (state_q == StRecv);

  im_loader_byte_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (pk_clear),
    .push_i      (pk_push),
    .byte_i      (bus.byte_data),
    .word_o      (pk_word),
    .word_full_o (pk_full)
  );

  always_comb begin
    state_d   = state_q;
    im_we_d   = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    done_d    = done_q;
    err_d     = err_q;
    count_d   = count_q;
    written_d = written_q;
    pk_clear  = 1'b0;
`ifdef IM_LOADER_CSUM_EN
    csum_d    = csum_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          waddr_d   = '0;
          written_d = '0;
          count_d   = bus.word_count;
          done_d    = 1'b0;
          err_d     = 1'b0;
          pk_clear  = 1'b1;
`ifdef IM_LOADER_CSUM_EN
          csum_d    = '0;
`endif
          if (bus.word_count == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else if (bus.word_count > MaxWords) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            state_d = StRecv;
          end
        end
      end
      StRecv: begin
`ifdef IM_LOADER_CSUM_EN
        if (accept) begin
          csum_d = csum_q ^ bus.byte_data;
        end
`endif
        if (pk_full) begin
          state_d = StWrite;
          im_we_d = 1'b1;
          wdata_d = pk_word;
        end
      end
      StWrite: begin
        // Address wraps naturally to 0 after a full-depth image.
        waddr_d   = waddr_q + ADDR_W'(1);
        written_d = written_q + CntW'(1);
        if (written_d == count_q) begin
`ifdef IM_LOADER_CSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = StRecv;
        end
      end
`ifdef IM_LOADER_CSUM_EN
      StCheck: begin
        if (accept) begin
          state_d = StDone;
          if (bus.byte_data != csum_q) begin
            err_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status outputs follow the state being entered so they are registered yet aligned.
    byte_ready_d = (state_d == StRecv) || (state_d == StCheck);
    cpu_hold_d   = (state_d != StDone);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      byte_ready_q <= 1'b0;
      im_we_q      <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= '0;
      written_q    <= '0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= byte_ready_d;
      im_we_q      <= im_we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
      count_q      <= count_d;
      written_q    <= written_d;
    end
  end

`ifdef IM_LOADER_CSUM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign bus.byte_ready = byte_ready_q;
  assign bus.im_we      = im_we_q;
  assign bus.im_waddr   = waddr_q;
  assign bus.im_wdata   = wdata_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  wr_t exp_q[$];
  logic [7:0] prog_q[$];

  im_loader_if #(.ADDR_W(ADDR_W)) bus ();

  im_loader #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every IM write must match the head of the expectation queue.
  task automatic monitor();
    logic prev_we = 1'b0;
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.im_we === 1'b1) begin
        check("we_single_cycle", {63'd0, prev_we}, 64'd0);
        check("hold_during_write", {63'd0, bus.cpu_hold}, 64'd1);
        check("write_expected", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("write_addr", {54'd0, bus.im_waddr}, 64'(e.addr));
          check("write_data", {32'd0, bus.im_wdata}, {32'd0, e.data});
        end
      end
      prev_we = bus.im_we;
    end
  endtask

  task automatic check_reset();
    @(negedge clk);
    check("rst_byte_ready", {63'd0, bus.byte_ready}, 64'd0);
    check("rst_im_we", {63'd0, bus.im_we}, 64'd0);
    check("rst_waddr", {54'd0, bus.im_waddr}, 64'd0);
    check("rst_wdata", {32'd0, bus.im_wdata}, 64'd0);
    check("rst_cpu_hold", {63'd0, bus.cpu_hold}, 64'd1);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_err", {63'd0, bus.err}, 64'd0);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that sampled start.
  task automatic pulse_start(input int n);
    bus.start = 1'b1;
    bus.word_count = n[ADDR_W:0];
    @(posedge clk);
    #1;
    start_cyc = cyc;
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data = b;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) begin
        @(posedge clk);
        #1;
        got = 1'b1;
      end
    end
    bus.byte_valid = 1'b0;
    check("byte_accepted", {63'd0, got}, 64'd1);
  endtask

  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: word i is bytes 4i..4i+3, most significant first, at address i mod depth.
  task automatic model_load(input int n);
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.addr = i % DEPTH;
      w.data = (32'(prog_q[4*i]) << 24) | (32'(prog_q[4*i+1]) << 16) |
               (32'(prog_q[4*i+2]) << 8) | 32'(prog_q[4*i+3]);
      exp_q.push_back(w);
    end
  endtask

  // gap_mode: 0 back-to-back, 1 idle before every odd byte, 2 random idles.
  task automatic run_load(input int n, input int gap_mode, input bit bad_csum,
                          input bit mid_start);
    logic [7:0] csum = 8'h00;
    bit seen = 1'b0;
    int extra = 0;
    model_load(n);
    for (int i = 0; i < 4 * n; i++) csum = csum ^ prog_q[i];
    pulse_start(n);
    for (int i = 0; i < 4 * n; i++) begin
      if (gap_mode == 1 && (i % 2) == 1) idle(1);
      if (gap_mode == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send_byte(prog_q[i]);
      if (mid_start && i == 2) begin
        bus.start = 1'b1;
        bus.word_count = '0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
    end
`ifdef IM_LOADER_CSUM_EN
    send_byte(csum ^ {7'd0, bad_csum});
    extra = 1;
`endif
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.err === 1'b1) seen = 1'b1;
    end
    check("load_finished", {63'd0, seen}, 64'd1);
    if (gap_mode == 0) check("load_cycles", 64'(cyc - start_cyc), 64'(5 * n + extra));
    check("end_done", {63'd0, bus.done}, {63'd0, !bad_csum});
    check("end_err", {63'd0, bus.err}, {63'd0, bad_csum});
    check("end_cpu_hold", {63'd0, bus.cpu_hold}, 64'd0);
    check("end_byte_ready", {63'd0, bus.byte_ready}, 64'd0);
    check("end_waddr", {54'd0, bus.im_waddr}, 64'(n % DEPTH));
    check("writes_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int nbytes);
    prog_q.delete();
    for (int i = 0; i < nbytes; i++) prog_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.word_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data = '0;
    repeat (2) @(posedge clk);
    check_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    fork
      monitor();
    join_none

    // Directed image, back-to-back then with toggled valid.
    prog_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_load(2, 0, 1'b0, 1'b0);
    run_load(2, 1, 1'b0, 1'b0);

    // Empty and oversize requests.
    pulse_start(0);
    @(negedge clk);
    check("zero_done", {63'd0, bus.done}, 64'd1);
    check("zero_err", {63'd0, bus.err}, 64'd0);
    check("zero_cpu_hold", {63'd0, bus.cpu_hold}, 64'd0);
    check("zero_waddr", {54'd0, bus.im_waddr}, 64'd0);
    @(posedge clk);
    #1;
    pulse_start(DEPTH + 1);
    @(negedge clk);
    check("over_err", {63'd0, bus.err}, 64'd1);
    check("over_done", {63'd0, bus.done}, 64'd0);
    check("over_cpu_hold", {63'd0, bus.cpu_hold}, 64'd0);
    check("over_byte_ready", {63'd0, bus.byte_ready}, 64'd0);
    idle(3);

    // Reset in the middle of a three-word load; only word 0 reaches IM.
    fill_random(12);
    model_load(1);
    pulse_start(3);
    for (int i = 0; i < 6; i++) send_byte(prog_q[i]);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    check_reset();
    check("abort_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    prog_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(1, 0, 1'b0, 1'b0);

    // Random images, random gaps, some with a stray start mid-load.
    for (int t = 0; t < 6; t++) begin
      int n = $urandom_range(1, 6);
      fill_random(4 * n);
      run_load(n, 2, 1'b0, bit'($urandom_range(0, 1)));
    end

    // Full-depth image: address wraps to 0 and no further writes.
    fill_random(4 * DEPTH);
    run_load(DEPTH, 0, 1'b0, 1'b0);
    idle(4);

`ifdef IM_LOADER_CSUM_EN
    prog_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(1, 0, 1'b0, 1'b0);
    run_load(1, 0, 1'b1, 1'b0);
`endif

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
